ratio_meas_ctrl: RTL
====================

Name: ratio_meas_ctrl

Overview:
- Sequencer for the clock-ratio measurement datapath.
- Holds the measured subsystem in reset for a programmable number of cycles, then releases it.
- Counts fast-domain and reference-domain tick strobes over a fixed reference window, then computes fast/ref with an iterative divider.
- Single clock domain. Both tick strobes arrive already synchronized to clk. Sits between the testbench/top-level control and the counter subsystem.

Parameters:
WIDTH, 32, width of counters, ratio and divider
RESET_CYCLES, 4, cycles sub_reset_l is held low after start (>=1)
WINDOW, 3, number of ref_tick strobes per measurement (>=1)

Ports:
clk  input  1  clock; all logic on posedge
reset_l  input  1  asynchronous active-low reset
start  input  1  pulse; begins a measurement when IDLE
abort  input  1  pulse; returns to IDLE from any state, no done
ref_tick  input  1  one-cycle strobe per reference-clock event
fast_tick  input  1  one-cycle strobe per fast-clock event
sub_reset_l  output  1  active-low reset to the measured subsystem
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when ratio is valid
ratio  output  WIDTH  fast_count / ref_count (integer quotient)
fast_count  output  WIDTH  fast ticks counted in the window
ref_count  output  WIDTH  ref ticks counted in the window
overflow  output  1  fast_count saturated during the last measurement

Behaviour:
- Reset (async, reset_l=0): state=IDLE. sub_reset_l=0, busy=0, done=0. ratio, fast_count, ref_count=0; overflow=0. First clk edge after reset release: sub_reset_l=1 (registered).
- IDLE: sub_reset_l=1. start=1 -> HOLD next cycle; clear fast_count, ref_count, overflow and the hold counter. ratio keeps its previous value until the DONE entry. start is ignored in every state other than IDLE.
- HOLD: sub_reset_l=0 for exactly RESET_CYCLES cycles; ticks are ignored. Then -> MEAS with sub_reset_l=1.
- MEAS:
  - fast_count += fast_tick and ref_count += ref_tick each cycle.
  - fast_count saturates at all-ones; saturating sets overflow (sticky until next start).
  - The cycle in which ref_tick brings ref_count to WINDOW -> DIV. A fast_tick in that same cycle is counted.
- DIV: restoring unsigned division, one quotient bit per cycle, MSB first, exactly WIDTH cycles. Divisor is ref_count (never 0 here). Counters are frozen.
- DONE: single cycle; done=1, ratio updated on entry (valid while done=1 and thereafter). -> IDLE.
- Latency: start sampled at cycle 0; HOLD cycles 1..RESET_CYCLES; MEAS from cycle RESET_CYCLES+1 to the final ref_tick at cycle M; DIV cycles M+1..M+WIDTH; done=1 at cycle M+WIDTH+1.
- abort: from any state -> IDLE next cycle. sub_reset_l=1, done not asserted; ratio and counters hold their current values. abort and start in the same IDLE cycle: abort wins, stay IDLE.
- reset_l asserted mid-operation: immediate return to reset values, including sub_reset_l=0.
- busy is combinational from state (state!=IDLE). All other outputs are registered.

Test Plan:
- Basic ratio: RESET_CYCLES=4, WINDOW=3, WIDTH=32; start at cycle 0; fast_tick every cycle; ref_tick on MEAS cycles 3, 7, 11 -> fast_count=12, ref_count=3, ratio=4, done one cycle at start+4+12+32+1, overflow=0.
- Reset hold: start -> sub_reset_l low exactly 4 cycles, busy high from cycle 1; ticks during HOLD do not change counts (both stay 0).
- Non-integer ratio: fast_tick on 10 of the 12 MEAS cycles, ref_tick 3 times -> fast_count=10, ratio=3 (truncated).
- Saturation: WIDTH=4; fast_tick every cycle, WINDOW=1, ref_tick after 20 MEAS cycles -> fast_count=15, overflow=1, ratio=15.
- Abort/collision: abort during DIV -> IDLE next cycle, no done, ratio unchanged from prior run. Start+abort together in IDLE -> stays IDLE, busy=0. Start during MEAS ignored.
- Async reset mid-MEAS: reset_l=0 between edges -> all outputs at reset values immediately, sub_reset_l=0. After release, sub_reset_l=1 and a fresh start completes normally.

Source files
------------

// File: rtl/ratio_meas_ctrl.sv
// Clock-ratio measurement sequencer: holds the measured block in reset, counts fast/ref
// ticks over a reference window, then divides fast by ref one quotient bit per cycle.
module ratio_meas_ctrl #(
  parameter int WIDTH        = 32,
  parameter int RESET_CYCLES = 4,
  parameter int WINDOW       = 3
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start,
  input  logic             abort,
  input  logic             ref_tick,
  input  logic             fast_tick,
  output logic             sub_reset_l,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ratio,
  output logic [WIDTH-1:0] fast_count,
  output logic [WIDTH-1:0] ref_count,
  output logic             overflow
);
  localparam int HC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int DC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, HOLD, MEAS, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [DC_W-1:0]  div_cnt_q, div_cnt_d;
  logic [WIDTH-1:0] fast_q, fast_d, ref_q, ref_d, ratio_q, ratio_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             ovf_q, ovf_d, done_q, done_d, sub_rst_q;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] quo_step, rem_step;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    div_cnt_d  = div_cnt_q;
    fast_d     = fast_q;
    ref_d      = ref_q;
    ovf_d      = ovf_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    ratio_d    = ratio_q;
    done_d     = 1'b0;
    // One restoring-division step: dividend bits shift out of quo_q into the remainder.
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, ref_q};
    quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    rem_step = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          fast_d     = '0;
          ref_d      = '0;
          ovf_d      = 1'b0;
        end
        HOLD: begin
          if (hold_cnt_q == HC_W'(RESET_CYCLES - 1)) state_d = MEAS;
          else hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
        MEAS: begin
          if (fast_tick) begin
            if (&fast_q) ovf_d = 1'b1;
            else fast_d = fast_q + WIDTH'(1);
          end
          if (ref_tick) begin
            ref_d = ref_q + WIDTH'(1);
            if (ref_d == WIDTH'(WINDOW)) begin
              state_d   = DIV;
              div_cnt_d = '0;
              quo_d     = fast_d;
              rem_d     = '0;
            end
          end
        end
        DIV: begin
          quo_d     = quo_step;
          rem_d     = rem_step;
          div_cnt_d = div_cnt_q + DC_W'(1);
          if (div_cnt_q == DC_W'(WIDTH - 1)) begin
            state_d = DONE;
            ratio_d = quo_step;
            done_d  = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      div_cnt_q  <= '0;
      fast_q     <= '0;
      ref_q      <= '0;
      ratio_q    <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      sub_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      div_cnt_q  <= div_cnt_d;
      fast_q     <= fast_d;
      ref_q      <= ref_d;
      ratio_q    <= ratio_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      sub_rst_q  <= (state_d != HOLD);
    end
  end

  assign busy        = (state_q != IDLE);
  assign sub_reset_l = sub_rst_q;
  assign done        = done_q;
  assign ratio       = ratio_q;
  assign fast_count  = fast_q;
  assign ref_count   = ref_q;
  assign overflow    = ovf_q;
endmodule
